// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Defaults target a 10 ms settle time at 25 MHz.
package switch_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, stability counter,
// debounced level flop and registered edge pulses.
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_switch};
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_s != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                // Held long enough: commit the new level and flag the edge.
                stable_d = sync_s;
                rise_d   = sync_s;
                fall_d   = ~sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_switch = stable_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Independent debouncers for a bank of raw board switches,
// feeding the switch-to-LED logic downstream.
module switch_debouncer
    import switch_debounce_pkg::*;
#(
    parameter int NUM_SWITCHES    = 2,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_SWITCHES-1:0] i_switch,
    output logic [NUM_SWITCHES-1:0] o_switch,
    output logic [NUM_SWITCHES-1:0] o_rise,
    output logic [NUM_SWITCHES-1:0] o_fall
);

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_switch (i_switch[g]),
            .o_switch (o_switch[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g])
        );
    end

endmodule
